// File: rtl/prefetch_cache_control.sv
// Two-way cache controller with a next-line prefetch launcher.
// Handles CPU read/write hits in IDLE, writes back dirty victims (WB),
// refills lines from memory (FILL), and stalls new misses in PF_WAIT while
// the prefetcher owns the memory port. Hit/miss counters saturate.
//
// Handshakes: mem_read/mem_write are held by the CPU until mem_resp, which
// is a one-cycle combinational acknowledge; pmem_read/pmem_write are held
// until pmem_resp; prefetch_start is a one-cycle launch acknowledged later
// by prefetch_done.
module prefetch_cache_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [31:0]      mem_address,
  input  logic             miss,
  input  logic             dirty_out,
  input  logic             way,
  input  logic             pmem_resp,
  input  logic             prefetch_done,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             data_in_sel,
  output logic             pmem_addr_sel,
  output logic [1:0]       wr_en_data_0_sel,
  output logic [1:0]       wr_en_data_1_sel,
  output logic             dirty_in,
  output logic             valid_in,
  output logic             ld_dirty_0,
  output logic             ld_dirty_1,
  output logic             ld_valid_0,
  output logic             ld_valid_1,
  output logic             ld_tag_0,
  output logic             ld_tag_1,
  output logic             ld_lru,
  output logic             prefetch_start,
  output logic [31:0]      cacheline_address,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {IDLE, PF_WAIT, WB, FILL} state_t;

  state_t state, next_state;
  logic   req, is_write;
  logic   pf_busy;
  logic   filled;   // current request was serviced by a FILL; its hit is not counted
  logic   launch;   // FILL completing this cycle

  assign req      = mem_read | mem_write;
  assign is_write = mem_write;  // read+write together is treated as a write
  assign launch   = (state == FILL) && pmem_resp;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic; misses only start memory traffic once the prefetcher is idle
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req && miss) begin
                 if (pf_busy)        next_state = PF_WAIT;
                 else if (dirty_out) next_state = WB;
                 else                next_state = FILL;
               end
      PF_WAIT: if (prefetch_done) next_state = IDLE;
      WB:      if (pmem_resp) next_state = req ? FILL : IDLE;
      FILL:    if (pmem_resp) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode; everything is forced low while reset is held
  always_comb begin
    mem_resp         = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    data_in_sel      = 1'b0;
    pmem_addr_sel    = 1'b0;
    wr_en_data_0_sel = 2'b00;
    wr_en_data_1_sel = 2'b00;
    dirty_in         = 1'b0;
    valid_in         = 1'b0;
    ld_dirty_0       = 1'b0;
    ld_dirty_1       = 1'b0;
    ld_valid_0       = 1'b0;
    ld_valid_1       = 1'b0;
    ld_tag_0         = 1'b0;
    ld_tag_1         = 1'b0;
    ld_lru           = 1'b0;
    if (rst) begin
      unique case (state)
        IDLE: if (req && !miss) begin
          mem_resp = 1'b1;
          ld_lru   = 1'b1;
          if (is_write) begin
            data_in_sel = 1'b1;
            dirty_in    = 1'b1;
            if (way) begin
              wr_en_data_1_sel = 2'b10;
              ld_dirty_1       = 1'b1;
            end else begin
              wr_en_data_0_sel = 2'b10;
              ld_dirty_0       = 1'b1;
            end
          end
        end
        PF_WAIT: ;
        WB: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b0;
        end
        FILL: begin
          pmem_read     = 1'b1;
          pmem_addr_sel = 1'b1;
          data_in_sel   = 1'b0;
          if (pmem_resp) begin
            valid_in = 1'b1;
            dirty_in = 1'b0;
            if (way) begin
              wr_en_data_1_sel = 2'b01;
              ld_tag_1         = 1'b1;
              ld_valid_1       = 1'b1;
              ld_dirty_1       = 1'b1;
            end else begin
              wr_en_data_0_sel = 2'b01;
              ld_tag_0         = 1'b1;
              ld_valid_0       = 1'b1;
              ld_dirty_0       = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Prefetch launch, busy tracking, fill flag and saturating counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      prefetch_start    <= 1'b0;
      cacheline_address <= 32'h0;
      pf_busy           <= 1'b0;
      filled            <= 1'b0;
      hit_count         <= '0;
      miss_count        <= '0;
    end else begin
      prefetch_start <= launch;
      if (launch) begin
        cacheline_address <= {mem_address[31:5] + 27'd1, 5'b0};
        pf_busy           <= 1'b1;
      end else if (prefetch_done) begin
        pf_busy <= 1'b0;
      end
      if (launch)
        filled <= 1'b1;
      else if (mem_resp || (state == IDLE && !req))
        filled <= 1'b0;
      if (mem_resp && !filled && hit_count != '1)
        hit_count <= hit_count + 1'b1;
      if (launch && miss_count != '1)
        miss_count <= miss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_prefetch_cache_control.sv
// Directed bench for prefetch_cache_control: a table of single-cycle hit
// vectors followed by hand-written multi-cycle miss, prefetch-wait, reset,
// wrap-around and saturation sequences. A second instance with narrow
// counters shares the stimulus so saturation is reachable quickly.
module tb_prefetch_cache_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, miss, dirty_out, way, pmem_resp, prefetch_done;
  logic [31:0] mem_address;

  logic        mem_resp, pmem_read, pmem_write, data_in_sel, pmem_addr_sel;
  logic [1:0]  wr0, wr1;
  logic        dirty_in, valid_in, ld_dirty_0, ld_dirty_1, ld_valid_0, ld_valid_1;
  logic        ld_tag_0, ld_tag_1, ld_lru, prefetch_start;
  logic [31:0] cacheline_address;
  logic [15:0] hit_count, miss_count;

  logic        s_mem_resp, s_pmem_read, s_pmem_write, s_data_in_sel, s_pmem_addr_sel;
  logic [1:0]  s_wr0, s_wr1;
  logic        s_dirty_in, s_valid_in, s_ld_dirty_0, s_ld_dirty_1, s_ld_valid_0, s_ld_valid_1;
  logic        s_ld_tag_0, s_ld_tag_1, s_ld_lru, s_prefetch_start;
  logic [31:0] s_cacheline_address;
  logic [2:0]  s_hit_count, s_miss_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  prefetch_cache_control dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .miss(miss), .dirty_out(dirty_out), .way(way),
    .pmem_resp(pmem_resp), .prefetch_done(prefetch_done), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .data_in_sel(data_in_sel),
    .pmem_addr_sel(pmem_addr_sel), .wr_en_data_0_sel(wr0), .wr_en_data_1_sel(wr1),
    .dirty_in(dirty_in), .valid_in(valid_in), .ld_dirty_0(ld_dirty_0),
    .ld_dirty_1(ld_dirty_1), .ld_valid_0(ld_valid_0), .ld_valid_1(ld_valid_1),
    .ld_tag_0(ld_tag_0), .ld_tag_1(ld_tag_1), .ld_lru(ld_lru),
    .prefetch_start(prefetch_start), .cacheline_address(cacheline_address),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  prefetch_cache_control #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .miss(miss), .dirty_out(dirty_out), .way(way),
    .pmem_resp(pmem_resp), .prefetch_done(prefetch_done), .mem_resp(s_mem_resp),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .data_in_sel(s_data_in_sel),
    .pmem_addr_sel(s_pmem_addr_sel), .wr_en_data_0_sel(s_wr0), .wr_en_data_1_sel(s_wr1),
    .dirty_in(s_dirty_in), .valid_in(s_valid_in), .ld_dirty_0(s_ld_dirty_0),
    .ld_dirty_1(s_ld_dirty_1), .ld_valid_0(s_ld_valid_0), .ld_valid_1(s_ld_valid_1),
    .ld_tag_0(s_ld_tag_0), .ld_tag_1(s_ld_tag_1), .ld_lru(s_ld_lru),
    .prefetch_start(s_prefetch_start), .cacheline_address(s_cacheline_address),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  typedef struct {
    logic       rd, wr, miss, dirty, way;
    logic       e_resp, e_lru, e_dsel;
    logic [1:0] e_wr0, e_wr1;
    logic       e_ldd0, e_ldd1, e_din;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read = 0; mem_write = 0; miss = 0; dirty_out = 0; way = 0;
    pmem_resp = 0; prefetch_done = 0; mem_address = 32'h0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1;
  endtask

  // One clean fill cycle sequence used for counter saturation
  task automatic clean_fill(input logic [31:0] addr, input logic w);
    mem_read = 1; mem_address = addr; miss = 1; way = w;
    next_cycle();
    pmem_resp = 1;
    next_cycle();
    pmem_resp = 0; miss = 0;
    next_cycle();
    mem_read = 0; prefetch_done = 1;
    next_cycle();
    prefetch_done = 0;
  endtask

  initial begin
    // Table of hit-path vectors applied in IDLE with the prefetcher idle
    //            rd wr ms dt wy  resp lru dsel wr0    wr1    ld0 ld1 din
    vecs[0] = '{1, 0, 0, 0, 0,   1,   1,  0,  2'b00, 2'b00, 0,  0,  0};
    vecs[1] = '{1, 0, 0, 1, 1,   1,   1,  0,  2'b00, 2'b00, 0,  0,  0};
    vecs[2] = '{0, 1, 0, 0, 0,   1,   1,  1,  2'b10, 2'b00, 1,  0,  1};
    vecs[3] = '{0, 1, 0, 0, 1,   1,   1,  1,  2'b00, 2'b10, 0,  1,  1};
    vecs[4] = '{1, 1, 0, 0, 1,   1,   1,  1,  2'b00, 2'b10, 0,  1,  1};
    vecs[5] = '{0, 0, 0, 0, 0,   0,   0,  0,  2'b00, 2'b00, 0,  0,  0};
    vecs[6] = '{0, 0, 1, 1, 1,   0,   0,  0,  2'b00, 2'b00, 0,  0,  0};
    vecs[7] = '{1, 1, 0, 1, 0,   1,   1,  1,  2'b10, 2'b00, 1,  0,  1};

    clear_inputs();
    rst = 0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_state", {prefetch_start, mem_resp, pmem_read, pmem_write}, 4'b0000);
    check("reset_addr", cacheline_address, 32'h0);
    check("reset_cnts", {hit_count, miss_count}, 32'h0);
    next_cycle();
    rst = 1;

    begin
      int exp_hits = 0;
      for (int i = 0; i < 8; i++) begin
        mem_read = vecs[i].rd; mem_write = vecs[i].wr; miss = vecs[i].miss;
        dirty_out = vecs[i].dirty; way = vecs[i].way; mem_address = 32'h100 + i * 4;
        @(negedge clk);
        check($sformatf("vec%0d_out", i),
              {mem_resp, ld_lru, data_in_sel, wr0, wr1, ld_dirty_0, ld_dirty_1, dirty_in,
               pmem_read, pmem_write},
              {vecs[i].e_resp, vecs[i].e_lru, vecs[i].e_dsel, vecs[i].e_wr0, vecs[i].e_wr1,
               vecs[i].e_ldd0, vecs[i].e_ldd1, vecs[i].e_din, 2'b00});
        check($sformatf("vec%0d_hits", i), hit_count, exp_hits);
        if ((vecs[i].rd || vecs[i].wr) && !vecs[i].miss) exp_hits++;
        next_cycle();
      end
      clear_inputs();
      @(negedge clk);
      check("table_hits_total", hit_count, exp_hits);
    end

    // Clean read miss at 0x1040, fill into way 1
    do_reset();
    mem_read = 1; mem_address = 32'h0000_1040; miss = 1; way = 1;
    @(negedge clk);
    check("cm_idle_no_resp", {mem_resp, pmem_read, ld_lru}, 3'b000);
    next_cycle();
    @(negedge clk);
    check("cm_fill_strobe", {pmem_read, pmem_addr_sel, data_in_sel, pmem_write}, 4'b1100);
    next_cycle();
    pmem_resp = 1;
    @(negedge clk);
    check("cm_fill_load", {wr1, wr0, ld_tag_1, ld_valid_1, valid_in, ld_dirty_1, dirty_in, ld_tag_0, ld_valid_0},
          {2'b01, 2'b00, 7'b1111000});
    check("cm_no_early_pf", prefetch_start, 1'b0);
    next_cycle();
    pmem_resp = 0; miss = 0;
    @(negedge clk);
    check("cm_resp", {mem_resp, ld_lru, pmem_read}, 3'b110);
    check("cm_pf_start", prefetch_start, 1'b1);
    check("cm_line_addr", cacheline_address, 32'h0000_1060);
    check("cm_miss_cnt", miss_count, 16'd1);
    next_cycle();
    mem_read = 0;
    @(negedge clk);
    check("cm_pf_pulse_end", prefetch_start, 1'b0);
    check("cm_hit_cnt", hit_count, 16'd0);
    check("cm_addr_hold", cacheline_address, 32'h0000_1060);
    next_cycle();

    // Miss while the prefetcher is busy: wait, then fill
    mem_read = 1; mem_address = 32'h0000_2000; miss = 1; way = 0;
    @(negedge clk);
    check("pw_idle_no_resp", mem_resp, 1'b0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("pw_hold%0d", i), {pmem_read, pmem_write, mem_resp}, 3'b000);
      next_cycle();
    end
    prefetch_done = 1;
    @(negedge clk);
    check("pw_done_no_strobe", {pmem_read, pmem_write}, 2'b00);
    next_cycle();
    prefetch_done = 0;
    @(negedge clk);
    check("pw_reeval_idle", {pmem_read, pmem_write, mem_resp}, 3'b000);
    next_cycle();
    pmem_resp = 1;
    @(negedge clk);
    check("pw_fill", {pmem_read, pmem_addr_sel, wr0}, {2'b11, 2'b01});
    next_cycle();
    pmem_resp = 0; miss = 0;
    @(negedge clk);
    check("pw_pf_addr", {prefetch_start, mem_resp, cacheline_address}, {2'b11, 32'h0000_2020});
    check("pw_miss_cnt", miss_count, 16'd2);
    next_cycle();
    mem_read = 0; prefetch_done = 1;
    next_cycle();
    prefetch_done = 0;

    // Reset asserted in the middle of a fill
    mem_read = 1; mem_address = 32'h0000_3000; miss = 1;
    next_cycle();
    @(negedge clk);
    check("rf_fill_active", pmem_read, 1'b1);
    next_cycle();
    rst = 0;
    next_cycle();
    @(negedge clk);
    check("rf_strobes_off", {pmem_read, pmem_write, mem_resp, prefetch_start, ld_tag_0, ld_tag_1}, 6'b0);
    check("rf_addr_reset", cacheline_address, 32'h0);
    check("rf_cnts_reset", {hit_count, miss_count}, 32'h0);
    next_cycle();
    rst = 1; miss = 0;
    @(negedge clk);
    check("rf_back_idle_hit", {mem_resp, pmem_read}, 2'b10);
    next_cycle();
    mem_read = 0;
    @(negedge clk);
    check("rf_hit_cnt", hit_count, 16'd1);

    // Dirty write miss: WB, FILL, then the write hit
    do_reset();
    mem_write = 1; mem_address = 32'h0000_4000; miss = 1; dirty_out = 1; way = 0;
    next_cycle();
    @(negedge clk);
    check("dw_wb", {pmem_write, pmem_addr_sel, pmem_read}, 3'b100);
    next_cycle();
    pmem_resp = 1;
    @(negedge clk);
    check("dw_wb_resp", pmem_write, 1'b1);
    next_cycle();
    pmem_resp = 0;
    @(negedge clk);
    check("dw_fill", {pmem_read, pmem_addr_sel, pmem_write, data_in_sel}, 4'b1100);
    next_cycle();
    pmem_resp = 1; dirty_out = 0;
    @(negedge clk);
    check("dw_fill_load", {wr0, ld_dirty_0, dirty_in, ld_tag_0, valid_in}, {2'b01, 4'b1011});
    next_cycle();
    pmem_resp = 0; miss = 0;
    @(negedge clk);
    check("dw_write_hit", {mem_resp, wr0, wr1, dirty_in, data_in_sel, ld_dirty_0},
          {1'b1, 2'b10, 2'b00, 3'b111});
    next_cycle();
    mem_write = 0;
    @(negedge clk);
    check("dw_cnts", {hit_count, miss_count}, {16'd0, 16'd1});
    next_cycle();

    // Line address wrap at the top of memory
    prefetch_done = 1;
    next_cycle();
    prefetch_done = 0;
    mem_read = 1; mem_address = 32'hFFFF_FFE4; miss = 1; way = 1;
    next_cycle();
    pmem_resp = 1;
    next_cycle();
    pmem_resp = 0; miss = 0;
    @(negedge clk);
    check("wrap_addr", {prefetch_start, cacheline_address}, {1'b1, 32'h0000_0000});
    next_cycle();
    mem_read = 0; prefetch_done = 1;
    next_cycle();
    prefetch_done = 0;

    // CPU drops its write during WB: finish WB, return idle silently
    mem_write = 1; mem_address = 32'h0000_5000; miss = 1; dirty_out = 1;
    next_cycle();
    mem_write = 0;
    @(negedge clk);
    check("drop_wb_held", pmem_write, 1'b1);
    next_cycle();
    pmem_resp = 1;
    next_cycle();
    pmem_resp = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("drop_idle%0d", i), {mem_resp, pmem_read, pmem_write}, 3'b000);
      next_cycle();
    end
    check("drop_miss_cnt", miss_count, 16'd2);
    clear_inputs();

    // Counter saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 10; i++) clean_fill(32'h0001_0000 + i * 32, i[0]);
    mem_read = 1; miss = 0;
    for (int i = 0; i < 10; i++) next_cycle();
    mem_read = 0;
    @(negedge clk);
    check("sat_wide", {hit_count, miss_count}, {16'd10, 16'd10});
    check("sat_narrow", {s_hit_count, s_miss_count}, {3'd7, 3'd7});

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/prefetch_cache_control.md
PREFETCH_CACHE_CONTROL -- requirements
Module: prefetch_cache_control

Interface
REQ-001 Parameter: CNT_W, default 16, width of the saturating hit/miss counters.
REQ-002 Ports (name, direction, width, meaning); clock and reset first:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- mem_read, mem_write  in  1 each  CPU request strobes, held until mem_resp.
- mem_address  in  32  CPU request address.
- miss, dirty_out, way  in  1 each  datapath status for the current index.
- pmem_resp  in  1  memory transaction complete.
- prefetch_done  in  1  prefetcher finished its line.
- mem_resp  out  1  CPU request complete.
- pmem_read, pmem_write  out  1 each  memory port strobes.
- data_in_sel, pmem_addr_sel  out  1 each  datapath mux selects.
- wr_en_data_0_sel, wr_en_data_1_sel  out  2 each  data write-enable selects: 00 none, 01 full line, 10 byte-enable.
- dirty_in, valid_in  out  1 each  array write values.
- ld_dirty_0, ld_dirty_1, ld_valid_0, ld_valid_1, ld_tag_0, ld_tag_1, ld_lru  out  1 each  array loads.
- prefetch_start  out  1  one-cycle prefetch launch pulse.
- cacheline_address  out  32  line address to prefetch.
- hit_count, miss_count  out  CNT_W each  performance counters.

Function
REQ-003 The FSM SHALL have the states IDLE, PF_WAIT, WB and FILL; every output not listed for a state SHALL be 0.
REQ-004 A request SHALL be active when mem_read or mem_write is high; if both are high, the request SHALL be handled as a write.
REQ-005 In IDLE with an active request and miss=0, the block SHALL assert mem_resp and ld_lru in the same cycle (combinational); the FSM SHALL stay in IDLE.
REQ-006 On a write hit, the block SHALL also assert, for the selected way only: data_in_sel=1, wr_en_data_<way>_sel=10, ld_dirty_<way>=1 and dirty_in=1.
REQ-007 In IDLE with an active request, miss=1 and pf_busy=1, the next state SHALL be PF_WAIT.
REQ-008 In IDLE with an active request, miss=1 and pf_busy=0, the next state SHALL be WB if dirty_out=1, otherwise FILL.
REQ-009 PF_WAIT SHALL hold until prefetch_done=1, then return to IDLE to re-evaluate the request; no pmem strobe SHALL be asserted in PF_WAIT.
REQ-010 WB SHALL assert pmem_write=1 and pmem_addr_sel=0; on pmem_resp the next state SHALL be FILL.
REQ-011 FILL SHALL assert pmem_read=1, pmem_addr_sel=1 and data_in_sel=0.
REQ-012 On pmem_resp in FILL, for way=lru, the block SHALL assert:
- wr_en_data_<way>_sel=01;
- ld_tag_<way>, ld_valid_<way> with valid_in=1;
- ld_dirty_<way> with dirty_in=0.
The next state SHALL then be IDLE, where the request hits.
REQ-013 The cycle after a FILL completes, the block SHALL pulse prefetch_start for exactly one cycle, set pf_busy, and drive cacheline_address = {mem_address[31:5]+1, 5'b0}.
REQ-014 The cacheline_address addition SHALL wrap modulo 2^32 (0xFFFFFFE0 -> 0x00000000); cacheline_address SHALL hold its value until the next launch.
REQ-015 pf_busy SHALL clear on prefetch_done; prefetch_done while pf_busy=0 SHALL be ignored.
REQ-016 A launch while pf_busy=1 is impossible; pf_busy SHALL gate all WB/FILL entry.
REQ-017 miss_count SHALL increment once per FILL completion.
REQ-018 hit_count SHALL increment on mem_resp only when the request did not require a FILL.
REQ-019 Both counters SHALL saturate at 2^CNT_W-1.
REQ-020 If the CPU drops its request mid-WB/FILL, the block SHALL complete the pmem transaction, then return to IDLE without asserting mem_resp.

Reset
REQ-021 With rst=0 at a clock edge, the block SHALL set: state IDLE, pf_busy 0, prefetch_start 0, cacheline_address 0, both counters 0.
REQ-022 Reset asserted mid-WB, mid-FILL or mid-PF_WAIT SHALL abort immediately with no further strobes.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Read hit (miss=0): mem_resp and ld_lru the same cycle; hit_count=1; no pmem strobe.
- Clean miss at 0x00001040: FILL, then pmem_resp; ld_tag/valid on the lru way, then mem_resp; one cycle later prefetch_start=1, cacheline_address=0x00001060, miss_count=1, hit_count=0.
- Dirty write miss: sequence WB -> FILL -> IDLE; pmem_addr_sel 0 then 1; final write sets wr_en=10 and dirty_in=1.
- Miss while pf_busy: held in PF_WAIT with no pmem strobes until prefetch_done, then proceeds to FILL.
- Address 0xFFFFFFE4 miss: cacheline_address=0x00000000; counter preloaded near max stays saturated at 0xFFFF.
- rst=0 during FILL: next cycle pmem_read=0, all outputs at reset values.
